// File: rtl/vector_mac_acc_gen_if.sv
// Operand and result stream bundle for vector_mac_acc_gen.
// master = operand producer / result consumer, slave = the MAC block.
interface vector_mac_acc_gen_if #(
  parameter int LANES = 4,
  parameter int W_EL  = 8,
  parameter int W_ACC = 32
);
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*W_EL-1:0]   in_a;
  logic [LANES*W_EL-1:0]   in_b;
  logic                    out_valid;
  logic                    out_ready;
  logic [W_ACC-1:0]        out_data;
  logic                    out_ovf;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/vector_mac_acc_gen.sv
// Parametrised LANES-wide multiply / lane-sum / frame-accumulate engine, 3-stage pipeline.
// Optional macro VMAC_SAT_EN selects saturating accumulation instead of wrap-around.
module vector_mac_acc_gen #(
  parameter int LANES = 4,
  parameter int W_EL  = 8,
  parameter int W_ACC = 32,
  parameter int W_CNT = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [W_CNT-1:0]       cfg_beats,
  input  logic                   cfg_signed,
  vector_mac_acc_gen_if.slave    bus,
  output logic                   busy
);

  localparam int P_W = 2*W_EL + 2;
  localparam int S_W = P_W + $clog2(LANES);
  // Wide enough that acc + lane sum never loses bits, so overflow is a range test.
  localparam int X_W = W_ACC + S_W;

  localparam logic [W_CNT-1:0] CNT_ONE = W_CNT'(1);
  localparam logic [W_ACC-1:0] ACC_MAX = {1'b0, {(W_ACC-1){1'b1}}};
  localparam logic [W_ACC-1:0] ACC_MIN = {1'b1, {(W_ACC-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  function automatic logic signed [W_EL:0] ext_el(input logic [W_EL-1:0] e, input logic sgn);
    return {sgn & e[W_EL-1], e};
  endfunction

  state_t                 state_r;
  logic [W_CNT-1:0]       beats_lat_r;
  logic [W_CNT-1:0]       cnt_r;
  logic                   mode_lat_r;

  logic                   accept_s;
  logic                   mode_eff_s;
  logic                   first_beat_s;
  logic                   last_beat_s;
  logic [W_CNT-1:0]       beats_eff_s;

  logic signed [W_EL:0]   ea_s, eb_s;
  logic signed [P_W-1:0]  pa_s, pb_s;
  logic signed [P_W-1:0]  prod_s [LANES];

  logic                   s1_valid_r, s1_first_r, s1_last_r;
  logic signed [P_W-1:0]  s1_prod_r [LANES];

  logic signed [S_W-1:0]  lane_ext_s;
  logic signed [S_W-1:0]  sum_s;
  logic                   s2_valid_r, s2_first_r, s2_last_r;
  logic signed [S_W-1:0]  s2_sum_r;

  logic signed [X_W-1:0]  sum_w_s, acc_w_s, res_w_s;
  logic [S_W:0]           res_top_s;
  logic                   add_ovf_s;
  logic [W_ACC-1:0]       acc_next_s;
  logic signed [W_ACC-1:0] acc_r;
  logic                   ovf_acc_r;
  logic                   s3_done_r;

  // Beat acceptance, mode/first/last decode; cfg is only looked at in IDLE.
  always_comb begin
    accept_s    = bus.in_valid && bus.in_ready;
    beats_eff_s = (cfg_beats == {W_CNT{1'b0}}) ? CNT_ONE : cfg_beats;
    if (state_r == IDLE) begin
      mode_eff_s   = cfg_signed;
      first_beat_s = 1'b1;
      last_beat_s  = (beats_eff_s == CNT_ONE);
    end else begin
      mode_eff_s   = mode_lat_r;
      first_beat_s = 1'b0;
      last_beat_s  = ((cnt_r + CNT_ONE) == beats_lat_r);
    end
  end

  // Per-lane extension and product.
  always_comb begin
    ea_s = '0;
    eb_s = '0;
    pa_s = '0;
    pb_s = '0;
    for (int i = 0; i < LANES; i++) begin
      ea_s      = ext_el(bus.in_a[i*W_EL +: W_EL], mode_eff_s);
      eb_s      = ext_el(bus.in_b[i*W_EL +: W_EL], mode_eff_s);
      pa_s      = ea_s;
      pb_s      = eb_s;
      prod_s[i] = pa_s * pb_s;
    end
  end

  // S1: register products with frame position tags.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_first_r <= 1'b0;
      s1_last_r  <= 1'b0;
      for (int i = 0; i < LANES; i++) s1_prod_r[i] <= '0;
    end else begin
      s1_valid_r <= accept_s;
      if (accept_s) begin
        s1_first_r <= first_beat_s;
        s1_last_r  <= last_beat_s;
        for (int i = 0; i < LANES; i++) s1_prod_r[i] <= prod_s[i];
      end
    end
  end

  // Lane reduction.
  always_comb begin
    sum_s      = '0;
    lane_ext_s = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_ext_s = s1_prod_r[i];
      sum_s      = sum_s + lane_ext_s;
    end
  end

  // S2: register the lane sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_r <= 1'b0;
      s2_first_r <= 1'b0;
      s2_last_r  <= 1'b0;
      s2_sum_r   <= '0;
    end else begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        s2_first_r <= s1_first_r;
        s2_last_r  <= s1_last_r;
        s2_sum_r   <= sum_s;
      end
    end
  end

  // Accumulate in a wide domain; overflow means the upper bits are not a pure sign extension.
  always_comb begin
    sum_w_s   = s2_sum_r;
    acc_w_s   = acc_r;
    if (s2_first_r) begin
      res_w_s = sum_w_s;
    end else begin
      res_w_s = acc_w_s + sum_w_s;
    end
    res_top_s = res_w_s[X_W-1:W_ACC-1];
    add_ovf_s = !((&res_top_s) || (~|res_top_s));
`ifdef VMAC_SAT_EN
    if (add_ovf_s) begin
      acc_next_s = res_w_s[X_W-1] ? ACC_MIN : ACC_MAX;
    end else begin
      acc_next_s = res_w_s[W_ACC-1:0];
    end
`else
    acc_next_s = res_w_s[W_ACC-1:0];
`endif
  end

  // S3: accumulator, sticky frame overflow and end-of-frame pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r     <= '0;
      ovf_acc_r <= 1'b0;
      s3_done_r <= 1'b0;
    end else begin
      s3_done_r <= s2_valid_r && s2_last_r;
      if (s2_valid_r) begin
        acc_r     <= acc_next_s;
        ovf_acc_r <= s2_first_r ? add_ovf_s : (ovf_acc_r | add_ovf_s);
      end
    end
  end

  // Frame control FSM with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      beats_lat_r   <= '0;
      cnt_r         <= '0;
      mode_lat_r    <= 1'b0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_ovf   <= 1'b0;
      busy          <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            beats_lat_r <= beats_eff_s;
            mode_lat_r  <= cfg_signed;
            cnt_r       <= CNT_ONE;
            busy        <= 1'b1;
            if (last_beat_s) begin
              state_r      <= DRAIN;
              bus.in_ready <= 1'b0;
            end else begin
              state_r      <= RUN;
            end
          end
        end
        RUN: begin
          if (accept_s) begin
            cnt_r <= cnt_r + CNT_ONE;
            if (last_beat_s) begin
              state_r      <= DRAIN;
              bus.in_ready <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (s3_done_r) begin
            state_r       <= HOLD;
            bus.out_valid <= 1'b1;
            bus.out_data  <= acc_r;
            bus.out_ovf   <= ovf_acc_r;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state_r       <= IDLE;
            bus.out_valid <= 1'b0;
            bus.out_ovf   <= 1'b0;
            bus.in_ready  <= 1'b1;
            busy          <= 1'b0;
          end
        end
        default: begin
          state_r       <= IDLE;
          bus.in_ready  <= 1'b1;
          bus.out_valid <= 1'b0;
          bus.out_ovf   <= 1'b0;
          busy          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vector_mac_acc_gen.sv
// Directed bench for vector_mac_acc_gen: a default 32-bit instance plus a W_ACC=20 instance
// sharing the same stimulus, with hand-computed expected results.
module tb_vector_mac_acc_gen;

  logic        clk;
  logic        rst;
  logic [15:0] cfg_beats;
  logic        cfg_signed;
  logic        busy;
  logic        busy20;

  int n_tests;
  int n_fail;

  vector_mac_acc_gen_if #(.LANES(4), .W_EL(8), .W_ACC(32)) bus ();
  vector_mac_acc_gen_if #(.LANES(4), .W_EL(8), .W_ACC(20)) bus20 ();

  assign bus20.in_valid  = bus.in_valid;
  assign bus20.in_a      = bus.in_a;
  assign bus20.in_b      = bus.in_b;
  assign bus20.out_ready = bus.out_ready;

  vector_mac_acc_gen #(.LANES(4), .W_EL(8), .W_ACC(32), .W_CNT(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_beats  (cfg_beats),
    .cfg_signed (cfg_signed),
    .bus        (bus),
    .busy       (busy)
  );

  vector_mac_acc_gen #(.LANES(4), .W_EL(8), .W_ACC(20), .W_CNT(16)) dut20 (
    .clk        (clk),
    .rst        (rst),
    .cfg_beats  (cfg_beats),
    .cfg_signed (cfg_signed),
    .bus        (bus20),
    .busy       (busy20)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_lanes(input logic [7:0] a, input logic [7:0] b);
    bus.in_a = {4{a}};
    bus.in_b = {4{b}};
  endtask

  // Present n beats; with gaps, one idle cycle follows each accept.
  task automatic send_beats(input string tag, input int n, input bit gaps);
    logic was;
    int   guard;
    for (int k = 0; k < n; k++) begin
      bus.in_valid = 1'b1;
      guard = 0;
      do begin
        was = bus.in_ready;
        tick();
        guard++;
      end while (!was && guard < 50);
      if (!was) check_eq({tag, "_accept"}, 64'(was), 64'd1);
      if (gaps) begin
        bus.in_valid = 1'b0;
        tick();
      end
    end
    bus.in_valid = 1'b0;
  endtask

  // Counts edges from the last accept until out_valid rises.
  task automatic wait_valid(input string tag, input int exp_lat);
    int lat;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    check_eq({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check_eq({tag, "_busy"}, 64'(busy), 64'd1);
    check_eq({tag, "_in_ready_hold"}, 64'(bus.in_ready), 64'd0);
  endtask

  task automatic handshake(input string tag, input logic [31:0] exp_data);
    bus.out_ready = 1'b1;
    tick();
    check_eq({tag, "_valid_clr"}, 64'(bus.out_valid), 64'd0);
    check_eq({tag, "_ovf_clr"}, 64'(bus.out_ovf), 64'd0);
    check_eq({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    check_eq({tag, "_idle"}, 64'(busy), 64'd0);
    check_eq({tag, "_data_kept"}, 64'(bus.out_data), 64'(exp_data));
  endtask

  initial begin
    int seen;
    n_tests       = 0;
    n_fail        = 0;
    rst           = 1'b1;
    cfg_beats     = 16'd1;
    cfg_signed    = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    set_lanes(8'h00, 8'h00);
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_eq("reset_in_ready", 64'(bus.in_ready), 64'd1);
    check_eq("reset_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("reset_out_data", 64'(bus.out_data), 64'd0);
    check_eq("reset_out_ovf", 64'(bus.out_ovf), 64'd0);
    check_eq("reset_busy", 64'(busy), 64'd0);

    // 250 beats of 4*255*255 = 260100 -> 65025000
    cfg_beats = 16'd250;
    set_lanes(8'hFF, 8'hFF);
    send_beats("u250", 250, 1'b0);
    wait_valid("u250", 3);
    check_eq("u250_data", 64'(bus.out_data), 64'd65025000);
    check_eq("u250_ovf", 64'(bus.out_ovf), 64'd0);
    handshake("u250", 32'd65025000);

    // 2 beats of 4*(-128*127) = -65024 -> -130048
    cfg_beats  = 16'd2;
    cfg_signed = 1'b1;
    set_lanes(8'h80, 8'h7F);
    send_beats("s2", 2, 1'b0);
    wait_valid("s2", 3);
    check_eq("s2_data", 64'(bus.out_data), 64'hFFFE0400);
    check_eq("s2_ovf", 64'(bus.out_ovf), 64'd0);
    handshake("s2", 32'hFFFE0400);
    cfg_signed = 1'b0;

    // Backpressure: result 4 held for 5 cycles while a new beat waits.
    cfg_beats     = 16'd1;
    bus.out_ready = 1'b0;
    set_lanes(8'h01, 8'h01);
    send_beats("bp", 1, 1'b0);
    wait_valid("bp", 3);
    bus.in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      check_eq("bp_hold_valid", 64'(bus.out_valid), 64'd1);
      check_eq("bp_hold_data", 64'(bus.out_data), 64'd4);
      check_eq("bp_hold_in_ready", 64'(bus.in_ready), 64'd0);
      check_eq("bp_hold_busy", 64'(busy), 64'd1);
    end
    bus.out_ready = 1'b1;
    tick();
    check_eq("bp_hs_valid", 64'(bus.out_valid), 64'd0);
    check_eq("bp_hs_in_ready", 64'(bus.in_ready), 64'd1);
    check_eq("bp_hs_busy", 64'(busy), 64'd0);
    tick();
    bus.in_valid = 1'b0;
    check_eq("bp_next_busy", 64'(busy), 64'd1);
    wait_valid("bp_next", 3);
    check_eq("bp_next_data", 64'(bus.out_data), 64'd4);
    handshake("bp_next", 32'd4);

    // 3 beats of 260100 = 780300: fits W_ACC=32, overflows W_ACC=20
    cfg_beats = 16'd3;
    set_lanes(8'hFF, 8'hFF);
    send_beats("w20", 3, 1'b0);
    wait_valid("w20", 3);
    check_eq("w20_acc32_data", 64'(bus.out_data), 64'd780300);
    check_eq("w20_acc32_ovf", 64'(bus.out_ovf), 64'd0);
    check_eq("w20_valid", 64'(bus20.out_valid), 64'd1);
`ifdef VMAC_SAT_EN
    check_eq("w20_data_sat", 64'(bus20.out_data), 64'h7FFFF);
`else
    // -268276 as 20-bit two's complement
    check_eq("w20_data_wrap", 64'(bus20.out_data), 64'hBE80C);
`endif
    check_eq("w20_ovf", 64'(bus20.out_ovf), 64'd1);
    handshake("w20", 32'd780300);
    check_eq("w20_ovf_clr", 64'(bus20.out_ovf), 64'd0);

    // cfg_beats=0 acts as 1: 4*2*3 = 24
    cfg_beats = 16'd0;
    set_lanes(8'h02, 8'h03);
    send_beats("zero", 1, 1'b1);
    wait_valid("zero", 2);
    check_eq("zero_data", 64'(bus.out_data), 64'd24);
    handshake("zero", 32'd24);

    // 4 unsigned beats of 4*255*1 = 1020 -> 4080; cfg changes mid-frame are ignored
    cfg_beats = 16'd4;
    set_lanes(8'hFF, 8'h01);
    send_beats("cfg", 1, 1'b1);
    cfg_beats  = 16'd1;
    cfg_signed = 1'b1;
    send_beats("cfg", 3, 1'b1);
    wait_valid("cfg", 2);
    check_eq("cfg_data", 64'(bus.out_data), 64'd4080);
    check_eq("cfg_ovf", 64'(bus.out_ovf), 64'd0);
    handshake("cfg", 32'd4080);
    cfg_signed = 1'b0;

    // Reset after 3 of 5 beats discards the frame.
    cfg_beats = 16'd5;
    set_lanes(8'h01, 8'h01);
    send_beats("rst", 3, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("rst_out_data", 64'(bus.out_data), 64'd0);
    check_eq("rst_out_ovf", 64'(bus.out_ovf), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (bus.out_valid === 1'b1) seen++;
    end
    check_eq("rst_no_result", 64'(seen), 64'd0);
    cfg_beats = 16'd1;
    set_lanes(8'h02, 8'h03);
    send_beats("post_rst", 1, 1'b0);
    wait_valid("post_rst", 3);
    check_eq("post_rst_data", 64'(bus.out_data), 64'd24);
    check_eq("post_rst_ovf", 64'(bus.out_ovf), 64'd0);
    handshake("post_rst", 32'd24);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
